// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The master side is the fetch/decode environment; the slave side is the queue.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_ready;
    logic [PTR_W:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: small circular FIFO of {pc, instr} entries between
// fetch and decode. Flush drops all entries; no bypass, so an entry is visible
// to decode one cycle after it is pushed at the earliest.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    fetch_queue_if.slave bus
);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wp_reg, wp_next;
    logic [PTR_W-1:0] rp_reg, rp_next;
    logic [PTR_W:0]   cnt_reg, cnt_next;
    logic [63:0]      entry_data [DEPTH];

    logic push;
    logic pop;

    // Status is decoded from registered occupancy only, never from inputs.
    assign bus.in_ready  = (cnt_reg != FULL_CNT);
    assign bus.out_valid = (cnt_reg != '0);
    assign bus.count     = cnt_reg;

    assign push = bus.in_valid  & bus.in_ready  & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    // Head entry; an empty queue presents a nop instead of stale array data.
    assign bus.out_pc    = bus.out_valid ? entry_data[rp_reg][63:32] : 32'h0000_0000;
    assign bus.out_instr = bus.out_valid ? entry_data[rp_reg][31:0]  : 32'h0000_0000;

    // Storage entries: written only on a push at their slot, never cleared.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] SLOT = gi;
            logic [63:0] entry_reg;

            // Capture the fetched pair when the write pointer targets this slot.
            always_ff @(posedge clk) begin
                if (push && (wp_reg == SLOT)) begin
                    entry_reg <= {bus.in_pc, bus.in_instr};
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wp_next  = wp_reg;
        rp_next  = rp_reg;
        cnt_next = cnt_reg;
        if (bus.flush) begin
            wp_next  = '0;
            rp_next  = '0;
            cnt_next = '0;
        end else begin
            if (push) begin
                wp_next = wp_reg + 1'b1;
            end
            if (pop) begin
                rp_next = rp_reg + 1'b1;
            end
            if (push && !pop) begin
                cnt_next = cnt_reg + 1'b1;
            end else if (pop && !push) begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    // Pointer and counter registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_reg  <= '0;
            rp_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            wp_reg  <= wp_next;
            rp_reg  <= rp_next;
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH = 4). Each vector gives
// the inputs for one cycle and the outputs expected in that same cycle, which
// reflect only the state left by earlier cycles.
module tb_fetch_queue;
    logic clk;
    logic reset;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic [31:0] ins,
                                logic ordy, logic e_ir, logic e_ov, logic [31:0] e_pc,
                                logic [31:0] e_ins, logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ir, input logic e_ov,
                             input logic [31:0] e_pc, input logic [31:0] e_ins,
                             input logic [2:0] e_cnt);
        check({tag, " in_ready"},  {31'd0, bus.in_ready},  {31'd0, e_ir});
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, e_ov});
        check({tag, " out_pc"},    bus.out_pc,             e_pc);
        check({tag, " out_instr"}, bus.out_instr,          e_ins);
        check({tag, " count"},     {29'd0, bus.count},     {29'd0, e_cnt});
        $display("[TB] %s: fl=%b iv=%b pc=%h ordy=%b -> ir=%b ov=%b out_pc=%h cnt=%0d",
                 tag, bus.flush, bus.in_valid, bus.in_pc, bus.out_ready,
                 bus.in_ready, bus.out_valid, bus.out_pc, bus.count);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
    endtask

    initial begin
        //                fl iv pc          ins            ordy ir ov e_pc        e_ins          cnt
        // Single push, then fill to four, refuse a fifth, drain in order.
        vecs[0]  = mk(0, 1, 32'h3000, 32'h3c010001, 0, 1, 0, 32'h0,    32'h0,        3'd0);
        vecs[1]  = mk(0, 1, 32'h3004, 32'h3c020002, 0, 1, 1, 32'h3000, 32'h3c010001, 3'd1);
        vecs[2]  = mk(0, 1, 32'h3008, 32'h3c030003, 0, 1, 1, 32'h3000, 32'h3c010001, 3'd2);
        vecs[3]  = mk(0, 1, 32'h300c, 32'h3c040004, 0, 1, 1, 32'h3000, 32'h3c010001, 3'd3);
        vecs[4]  = mk(0, 1, 32'h3010, 32'h3c050005, 0, 0, 1, 32'h3000, 32'h3c010001, 3'd4);
        vecs[5]  = mk(0, 0, 32'h0,    32'h0,        1, 0, 1, 32'h3000, 32'h3c010001, 3'd4);
        vecs[6]  = mk(0, 0, 32'h0,    32'h0,        1, 1, 1, 32'h3004, 32'h3c020002, 3'd3);
        vecs[7]  = mk(0, 0, 32'h0,    32'h0,        1, 1, 1, 32'h3008, 32'h3c030003, 3'd2);
        vecs[8]  = mk(0, 0, 32'h0,    32'h0,        1, 1, 1, 32'h300c, 32'h3c040004, 3'd1);
        vecs[9]  = mk(0, 0, 32'h0,    32'h0,        1, 1, 0, 32'h0,    32'h0,        3'd0);
        vecs[10] = mk(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'h0,    32'h0,        3'd0);
        // Full queue with simultaneous pop request and push attempt.
        vecs[11] = mk(0, 1, 32'h3000, 32'h3c010001, 0, 1, 0, 32'h0,    32'h0,        3'd0);
        vecs[12] = mk(0, 1, 32'h3004, 32'h3c020002, 0, 1, 1, 32'h3000, 32'h3c010001, 3'd1);
        vecs[13] = mk(0, 1, 32'h3008, 32'h3c030003, 0, 1, 1, 32'h3000, 32'h3c010001, 3'd2);
        vecs[14] = mk(0, 1, 32'h300c, 32'h3c040004, 0, 1, 1, 32'h3000, 32'h3c010001, 3'd3);
        vecs[15] = mk(0, 1, 32'h3010, 32'h3c050005, 1, 0, 1, 32'h3000, 32'h3c010001, 3'd4);
        vecs[16] = mk(0, 1, 32'h3010, 32'h3c050005, 0, 1, 1, 32'h3004, 32'h3c020002, 3'd3);
        vecs[17] = mk(0, 0, 32'h0,    32'h0,        0, 0, 1, 32'h3004, 32'h3c020002, 3'd4);
        // Drop to three, then flush with push and pop requested.
        vecs[18] = mk(0, 0, 32'h0,    32'h0,        1, 0, 1, 32'h3004, 32'h3c020002, 3'd4);
        vecs[19] = mk(1, 1, 32'h4000, 32'hdeadbeef, 1, 1, 1, 32'h3008, 32'h3c030003, 3'd3);
        vecs[20] = mk(0, 1, 32'h5000, 32'h11111111, 0, 1, 0, 32'h0,    32'h0,        3'd0);
        vecs[21] = mk(0, 0, 32'h0,    32'h0,        0, 1, 1, 32'h5000, 32'h11111111, 3'd1);
        vecs[22] = mk(0, 0, 32'h0,    32'h0,        1, 1, 1, 32'h5000, 32'h11111111, 3'd1);
        vecs[23] = mk(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'h0,    32'h0,        3'd0);
        // Flush while empty leaves the queue empty.
        vecs[24] = mk(1, 1, 32'h7000, 32'h22222222, 1, 1, 0, 32'h0,    32'h0,        3'd0);
        vecs[25] = mk(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'h0,    32'h0,        3'd0);

        drive(0, 0, 32'h0, 32'h0, 0);
        reset = 1'b1;
        #1;
        check_all("reset", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                      vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_cnt);
        end

        // Streaming ten entries with push and pop every cycle, across the wrap.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) begin
                drive(0, 1, 32'h6000 + 32'(4 * k), 32'ha0000000 + 32'(k), 1);
            end else begin
                drive(0, 0, 32'h0, 32'h0, 1);
            end
            #1;
            if (k == 0) begin
                check_all("s0", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
            end else begin
                check_all($sformatf("s%0d", k), 1'b1, 1'b1, 32'h6000 + 32'(4 * (k - 1)),
                          32'ha0000000 + 32'(k - 1), 3'd1);
            end
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0);
        #1;
        check_all("s_end", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        // Reset asserted between edges with two entries buffered.
        drive(0, 1, 32'h8000, 32'h33333333, 0);
        @(negedge clk);
        drive(0, 1, 32'h8004, 32'h44444444, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0);
        #1;
        check_all("r_pre", 1'b1, 1'b1, 32'h8000, 32'h33333333, 3'd2);
        #1;
        reset = 1'b1;
        #1;
        check_all("r_async", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 32'h3000, 32'h3c010001, 0);
        #1;
        check_all("r_push", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0);
        #1;
        check_all("r_head", 1'b1, 1'b1, 32'h3000, 32'h3c010001, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch unit and the decode stage. Each entry holds a fetched PC and instruction word and is buffered in a small circular FIFO, so fetch keeps running while decode stalls. A flush input drops every buffered entry on a control-flow redirect. Decode always sees the oldest entry, with a one-cycle minimum fetch-to-decode latency.

## Interface
- DEPTH, 4, number of entries; a power of two, at least 2
- PTR_W, log2(DEPTH), width of the read and write pointers

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears the queue
- flush  input  1  synchronous; discards all entries at the next edge
- in_valid  input  1  fetch presents an entry
- in_pc  input  32  PC of the fetched instruction
- in_instr  input  32  fetched instruction word
- in_ready  output  1  queue can accept an entry this cycle
- out_valid  output  1  head entry is valid
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction word of the head entry
- out_ready  input  1  decode consumes the head entry this cycle
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH x 64-bit array holding {pc, instr}, plus write pointer wp, read pointer rp and an occupancy counter cnt. Both pointers wrap modulo DEPTH.
- Push = in_valid & in_ready & ~flush. It writes {in_pc, in_instr} at wp, then wp++.
- Pop = out_valid & out_ready & ~flush. It increments rp.
- cnt next value:
  - push only: cnt+1
  - pop only: cnt-1
  - both or neither: unchanged
- Output decodes:
  - in_ready = (cnt != DEPTH)
  - out_valid = (cnt != 0)
  - count = cnt
  - These are decoded from registered state only; no combinational path from in_* to out_* or from out_ready to in_ready.
- No bypass. An entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest, even when the queue was empty.
- When out_valid = 0: out_pc = 32'h00000000 and out_instr = 32'h00000000 (nop), regardless of array contents.
- Full queue: in_ready = 0, so no push, even if a pop happens in the same cycle. in_ready rises in the cycle after the pop.
- Empty queue: out_valid = 0; out_ready is ignored and there is no underflow.
- Flush has priority over push and pop.
  - At the next edge: wp = rp = 0, cnt = 0.
  - Data presented in the flush cycle is discarded.
  - Array contents are don't-care.
- Array contents are not cleared by reset or flush; only the pointers and counter are.
- Values in the array that have been written and not yet popped are never overwritten.

## Timing
- Reset (asynchronous assert, independent of clk):
  - wp = rp = cnt = 0
  - in_ready = 1, out_valid = 0, count = 0, out_pc = 0, out_instr = 0
- Reset deassertion: first push can be accepted at the first rising edge after deassertion.
- Latency: in to out is 1 cycle. Sustained throughput is 1 entry per cycle when out_ready is held high.
- Simultaneous push and pop at 0 < cnt < DEPTH: cnt holds, both pointers advance, and the head moves to the next-oldest entry.
- Pointer wrap: after DEPTH pushes, wp returns to 0; FIFO order is preserved across the wrap.
- Reset asserted mid-operation: all entries are lost immediately, and outputs take their reset values without waiting for a clock edge.
- Flush while full or empty: the result is identical, cnt = 0 after the edge.

## Test plan
- Reset, then push PC 0x3000/instr 0x3c010001 while out_ready = 0:
  - next cycle: out_valid = 1, out_pc = 0x3000, out_instr = 0x3c010001, count = 1
  - in the push cycle itself: out_valid = 0, out_instr = 0.
- Push 4 entries (PC 0x3000..0x300c) with out_ready = 0:
  - after the 4th: count = 4, in_ready = 0
  - a 5th in_valid is not accepted
  - then out_ready = 1 for 4 cycles: out_pc is 0x3000, 0x3004, 0x3008, 0x300c in order, then out_valid = 0.
- Stream 10 entries with in_valid = out_ready = 1 continuously:
  - count stays at 1 after the first cycle
  - out_pc follows in_pc with 1-cycle delay across the pointer wrap.
- Full queue (count = 4) with out_ready = 1 and in_valid = 1 in the same cycle:
  - pop occurs, no push, count = 3
  - next cycle in_ready = 1 and a push is accepted.
- count = 3, assert flush with in_valid = out_ready = 1:
  - next cycle count = 0, out_valid = 0, in_ready = 1, out_pc = 0
  - a push in the following cycle appears as the head one cycle later.
- count = 2, assert reset between clock edges:
  - out_valid = 0, count = 0, in_ready = 1 immediately, before the next edge
  - after deassertion, a new push at PC 0x3000 is output first.
